// File: rtl/ntt_pkg.sv
// Shared constants for the NTT modular multiplier: pipeline latency and the
// Barrett parameters for the two supported primes.
package ntt_pkg;

    localparam int NTT_MULT_LAT = 4;

    // q = 3329, K = 12, mu = floor(2^24 / 3329)
    localparam int Q_3329_K  = 12;
    localparam int Q_3329    = 3329;
    localparam int MU_3329   = 5039;

    // q = 7681, K = 13, mu = floor(2^26 / 7681)
    localparam int Q_7681_K  = 13;
    localparam int Q_7681    = 7681;
    localparam int MU_7681   = 8736;

endpackage

// File: rtl/barrett_final_reduce.sv
// Final Barrett correction: brings r from 0..3q-1 into 0..q-1 with at most
// two conditional subtractions of q. Purely combinational.
module barrett_final_reduce #(
    parameter int DATA_WIDTH = 16,
    parameter int MOD_BITS   = 12
) (
    input  logic [MOD_BITS+1:0]   r_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int EW = DATA_WIDTH + 3;

    function automatic logic [EW-1:0] cond_sub(input logic [EW-1:0] x,
                                               input logic [EW-1:0] q);
        return (x >= q) ? (x - q) : x;
    endfunction

    logic [EW-1:0] r1;
    logic [EW-1:0] r2;
    logic          unused_hi;

    always_comb begin
        r1 = cond_sub(EW'(r_i), EW'(q_i));
        r2 = cond_sub(r1, EW'(q_i));
    end

    assign result_o  = r2[DATA_WIDTH-1:0];
    assign unused_hi = ^r2[EW-1:DATA_WIDTH];

endmodule

// File: rtl/ntt_mod_mult.sv
// Four-stage Barrett modular multiplier (a*b mod q) with valid/ready and a
// global stall. Define NTT_MULT_TAG_EN to carry a user tag alongside each operation.
module ntt_mod_mult
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MOD_BITS   = 12
`ifdef NTT_MULT_TAG_EN
    ,
    parameter int TAG_WIDTH  = 8
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] modulus_i,
    input  logic [MOD_BITS+1:0]   mu_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
`ifdef NTT_MULT_TAG_EN
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic [TAG_WIDTH-1:0]  tag_o,
`endif
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int RW = MOD_BITS + 2;
    localparam int MW = PW + RW;
    localparam int TW = RW + DATA_WIDTH;

    logic [NTT_MULT_LAT-1:0] vld_q, vld_d;
    logic [PW-1:0]           prod_p1_q, prod_p1_d;
    logic [RW-1:0]           plo_p2_q, plo_p2_d;
    logic [RW-1:0]           t_p2_q, t_p2_d;
    logic [RW-1:0]           r_p3_q, r_p3_d;
    logic [DATA_WIDTH-1:0]   res_p4_q, res_p4_d;
    logic [DATA_WIDTH-1:0]   res_red;
    logic [MW-1:0]           qm_full;
    logic [TW-1:0]           tq_full;
    logic                    adv;
    logic                    unused_bits;

    // One stall signal freezes every stage while the output is blocked.
    assign ready_o = !(vld_q[NTT_MULT_LAT-1] && !ready_i);
    assign adv     = ready_o;

    assign qm_full = MW'(prod_p1_q >> (MOD_BITS - 1)) * MW'(mu_i);
    assign tq_full = TW'(t_p2_q) * TW'(modulus_i);

    // r = p - t*q is exact modulo 2^(K+2) because the true value is below 3q.
    assign unused_bits = ^{qm_full[MOD_BITS:0], qm_full[MW-1:MOD_BITS+1+RW], tq_full[TW-1:RW]};

    barrett_final_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .MOD_BITS   (MOD_BITS)
    ) u_final (
        .r_i      (r_p3_q),
        .q_i      (modulus_i),
        .result_o (res_red)
    );

    always_comb begin
        vld_d     = vld_q;
        prod_p1_d = prod_p1_q;
        plo_p2_d  = plo_p2_q;
        t_p2_d    = t_p2_q;
        r_p3_d    = r_p3_q;
        res_p4_d  = res_p4_q;
        if (adv) begin
            vld_d = {vld_q[NTT_MULT_LAT-2:0], valid_i};
            if (valid_i) begin
                prod_p1_d = PW'(a_i) * PW'(b_i);
            end
            if (vld_q[0]) begin
                t_p2_d   = qm_full[MOD_BITS+1 +: RW];
                plo_p2_d = prod_p1_q[RW-1:0];
            end
            if (vld_q[1]) begin
                r_p3_d = plo_p2_q - tq_full[RW-1:0];
            end
            if (vld_q[2]) begin
                res_p4_d = res_red;
            end
        end
        if (clear_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            prod_p1_q <= '0;
            plo_p2_q  <= '0;
            t_p2_q    <= '0;
            r_p3_q    <= '0;
            res_p4_q  <= '0;
        end else begin
            vld_q     <= vld_d;
            prod_p1_q <= prod_p1_d;
            plo_p2_q  <= plo_p2_d;
            t_p2_q    <= t_p2_d;
            r_p3_q    <= r_p3_d;
            res_p4_q  <= res_p4_d;
        end
    end

    assign valid_o  = vld_q[NTT_MULT_LAT-1];
    assign result_o = res_p4_q;

`ifdef NTT_MULT_TAG_EN
    logic [NTT_MULT_LAT-1:0][TAG_WIDTH-1:0] tag_q, tag_d;

    always_comb begin
        tag_d = tag_q;
        if (adv) begin
            if (valid_i) begin
                tag_d[0] = tag_i;
            end
            for (int s = 1; s < NTT_MULT_LAT; s++) begin
                if (vld_q[s-1]) begin
                    tag_d[s] = tag_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q[NTT_MULT_LAT-1];
`endif

endmodule
